// File: rtl/ahblite_keypad_scanner.sv
// AHB-Lite 4x4 keypad scanner: row drive, column sync/debounce, single-key capture with OVF/IRQ.
// Optional auto-repeat of a held key is built when KEYPAD_AUTOREPEAT_EN is defined.
module ahblite_keypad_scanner #(
    parameter int unsigned SCAN_DIV      = 1000,
    parameter int unsigned DEBOUNCE_CNT  = 4,
    parameter int unsigned REPEAT_FRAMES = 64
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HSIZE,
    input  logic [3:0]  HPROT,
    input  logic        HWRITE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [31:0] HRDATA,
    output logic        HRESP,
    output logic [3:0]  Row,
    input  logic [3:0]  Col,
    output logic        IRQ
);
    localparam int unsigned DW = $clog2(SCAN_DIV);
    localparam int unsigned CW = $clog2(DEBOUNCE_CNT + 1);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t      state_q, state_d;
    logic [1:0]  addr_q;
    logic        wr_q, rd_q;
    logic        en_q, en_d, ie_q, ie_d;
    logic [3:0]  col_meta_q, col_sync_q;
    logic [1:0]  row_idx_q, row_idx_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [15:0] frame_q, frame_d, frame_full;
    logic [15:0] prev_q, prev_d, stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]  code_q, code_d, enc;
    logic        valid_q, valid_d, ovf_q, ovf_d, irq_q;
    logic        frame_end, single, press_evt, evt;
    logic        addr_ph, ctrl_wr, stat_wr, key_rd, held;

    logic unused_ok;
    assign unused_ok = &{1'b0, HSIZE, HPROT, HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA[31:2]};

    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
    assign IRQ       = irq_q;

    assign addr_ph = HSEL & HTRANS[1] & HREADY;
    assign ctrl_wr = wr_q && (addr_q == 2'd0);
    assign stat_wr = wr_q && (addr_q == 2'd1);
    assign key_rd  = rd_q && (addr_q == 2'd2);
    assign en_d    = ctrl_wr ? HWDATA[0] : en_q;
    assign ie_d    = ctrl_wr ? HWDATA[1] : ie_q;
    assign held    = (stable_q != '0);

    always_comb begin
        Row = 4'hF;
        if (state_q == SCAN) Row = ~(4'b0001 << row_idx_q);
    end

    // en_d is used so a write clearing EN parks the scanner at the same edge it lands.
    always_comb begin
        state_d    = state_q;
        row_idx_d  = row_idx_q;
        dwell_d    = dwell_q;
        frame_d    = frame_q;
        prev_d     = prev_q;
        cnt_d      = cnt_q;
        stable_d   = stable_q;
        frame_full = frame_q;
        frame_end  = 1'b0;
        case (state_q)
            IDLE: if (en_d) state_d = SCAN;
            SCAN: begin
                if (!en_d) begin
                    state_d   = IDLE;
                    row_idx_d = '0;
                    dwell_d   = '0;
                    frame_d   = '0;
                    prev_d    = '0;
                    cnt_d     = '0;
                    stable_d  = '0;
                end else if (dwell_q == DW'(SCAN_DIV - 1)) begin
                    dwell_d = '0;
                    frame_full[{row_idx_q, 2'b00} +: 4] = ~col_sync_q;
                    frame_d   = frame_full;
                    row_idx_d = row_idx_q + 2'd1;
                    if (row_idx_q == 2'd3) begin
                        frame_end = 1'b1;
                        if (frame_full != prev_q)            cnt_d = CW'(1);
                        else if (cnt_q != CW'(DEBOUNCE_CNT)) cnt_d = cnt_q + CW'(1);
                        prev_d = frame_full;
                        if (cnt_d == CW'(DEBOUNCE_CNT)) stable_d = frame_full;
                    end
                end else begin
                    dwell_d = dwell_q + DW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Events only fire on a zero -> one-hot transition, which also blocks ghosted maps.
    assign single    = (stable_d != '0) && ((stable_d & (stable_d - 16'd1)) == '0);
    assign press_evt = (stable_q == '0) && single;

    always_comb begin
        enc = '0;
        for (int unsigned i = 0; i < 16; i++)
            if (stable_d[i]) enc = 4'(i);
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int unsigned RW = $clog2(REPEAT_FRAMES + 1);
    logic [RW-1:0] rep_q, rep_d;
    logic          rep_evt;

    always_comb begin
        rep_d   = rep_q;
        rep_evt = 1'b0;
        if (!en_d || (stable_d != stable_q)) begin
            rep_d = '0;
        end else if (frame_end && single && (cnt_d == CW'(DEBOUNCE_CNT))) begin
            if (rep_q == RW'(REPEAT_FRAMES - 1)) begin
                rep_d   = '0;
                rep_evt = 1'b1;
            end else begin
                rep_d = rep_q + RW'(1);
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn)
        if (!HRESETn) rep_q <= '0;
        else          rep_q <= rep_d;

    assign evt = press_evt | rep_evt;
`else
    assign evt = press_evt;
`endif

    always_comb begin
        code_d  = code_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        if (stat_wr && HWDATA[1]) ovf_d = 1'b0;
        if (key_rd) valid_d = 1'b0;
        if (evt) begin
            if (!valid_q || key_rd) begin
                code_d  = enc;
                valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_comb begin
        HRDATA = '0;
        case (addr_q)
            2'd0: HRDATA = {30'b0, ie_q, en_q};
            2'd1: HRDATA = {29'b0, held, ovf_q, valid_q};
            2'd2: HRDATA = {27'b0, valid_q, code_q};
            2'd3: HRDATA = {24'b0, Row, col_sync_q};
            default: HRDATA = '0;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            en_q       <= 1'b0;
            ie_q       <= 1'b0;
            col_meta_q <= '0;
            col_sync_q <= '0;
            row_idx_q  <= '0;
            dwell_q    <= '0;
            frame_q    <= '0;
            prev_q     <= '0;
            cnt_q      <= '0;
            stable_q   <= '0;
            code_q     <= '0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            if (addr_ph) addr_q <= HADDR[3:2];
            wr_q       <= addr_ph & HWRITE;
            rd_q       <= addr_ph & ~HWRITE;
            en_q       <= en_d;
            ie_q       <= ie_d;
            col_meta_q <= Col;
            col_sync_q <= col_meta_q;
            row_idx_q  <= row_idx_d;
            dwell_q    <= dwell_d;
            frame_q    <= frame_d;
            prev_q     <= prev_d;
            cnt_q      <= cnt_d;
            stable_q   <= stable_d;
            code_q     <= code_d;
            valid_q    <= valid_d;
            ovf_q      <= ovf_d;
            irq_q      <= ie_d & (valid_d | ovf_d);
        end
    end
endmodule

// File: doc/ahblite_keypad_scanner.md
Name: ahblite_keypad_scanner

Overview:
- AHB-Lite slave that autonomously scans a 4x4 matrix keypad. Software no longer drives rows or polls columns.
- Hardware cycles the rows, synchronises and debounces the columns, and detects single-key presses.
- Each press is latched as a 4-bit key code with status, overflow and an interrupt.
- Sits on the AHB-Lite matrix alongside the other peripherals; Row/Col go to the keypad pins.

Parameters:
- SCAN_DIV, 1000: HCLK cycles each row is driven (dwell); must be >= 4.
- DEBOUNCE_CNT, 4: consecutive identical frames needed before a frame is accepted as stable; must be >= 1.
- REPEAT_FRAMES, 64: stable frames between auto-repeat events; used only with the optional feature.

Ports:
- HCLK  in  1  system clock
- HRESETn  in  1  asynchronous active-low reset
- HSEL  in  1  slave select
- HADDR  in  32  address; [3:2] decoded
- HTRANS  in  2  transfer type; HTRANS[1] = active
- HSIZE  in  3  ignored; word access assumed
- HPROT  in  4  ignored
- HWRITE  in  1  1 = write
- HWDATA  in  32  write data (data phase)
- HREADY  in  1  bus ready
- HREADYOUT  out  1  constant 1
- HRDATA  out  32  read data
- HRESP  out  1  constant 0
- Row  out  4  row drive, active-low one-hot
- Col  in  4  column sense, active-low (pulled up), asynchronous
- IRQ  out  1  level interrupt

Behaviour:
- Reset: all registers 0, FSM IDLE, Row=4'hF, IRQ=0. Reset is asynchronous and may arrive at any time; it aborts any scan.
- Bus address phase:
  - Captured when HSEL&HTRANS[1]&HREADY: register the address, write flag and read flag.
  - Writes take effect on the data-phase cycle, using HWDATA.
  - Read side effects also take effect on the data-phase cycle. Zero wait states.
- Register map:
  - 0x00 CTRL (RW): bit0 EN, bit1 IE.
  - 0x04 STATUS: bit0 VALID (RO), bit1 OVF (W1C), bit2 HELD (RO).
  - 0x08 KEY (RO): [3:0] code, bit4 VALID. A read returns the current value and clears VALID.
  - 0x0C RAW (RO): {24'b0, Row, Col_sync}.
  - Unused bits read 0.
- Col path: 2-FF synchroniser into Col_sync; adds 2 cycles of latency.
- FSM IDLE: Row=4'hF. Moves to SCAN when EN=1.
- FSM SCAN:
  - row_idx 0..3; Row = ~(1<<row_idx).
  - A dwell counter runs 0..SCAN_DIV-1. On the last dwell cycle, ~Col_sync is stored into frame bits [row_idx*4+3 : row_idx*4], then row_idx increments and wraps 3->0.
  - The wrap from 3 to 0 ends a frame; do EVAL in that same cycle.
- EVAL:
  - Frame != previous frame: reset the stable counter to 1.
  - Frame == previous frame: increment the counter, saturating at DEBOUNCE_CNT.
  - Counter reaching DEBOUNCE_CNT: frame becomes stable_map.
  - Press event: stable_map goes from zero to exactly one bit set. Code = row*4+col of that bit.
  - Two or more bits set (ghosting): no event, HELD=1, no new event until stable_map returns to zero.
  - HELD = (stable_map != 0).
- Holding register:
  - Event with VALID=0: store code, VALID=1.
  - Event with VALID=1 and no KEY read this cycle: keep the old code, OVF=1.
  - Event and KEY read in the same cycle: store the new code, VALID stays 1, no OVF.
  - OVF write-1-clear and a new overflow in the same cycle: OVF stays 1.
- EN cleared mid-frame:
  - Next cycle: IDLE, Row=4'hF.
  - row_idx, dwell, frame, previous frame, stable counter, stable_map and HELD are cleared.
  - KEY, VALID and OVF are retained.
- IRQ = IE & (VALID | OVF), registered.

Optional Feature:
- Macro: KEYPAD_AUTOREPEAT_EN.
- Defined: while stable_map holds exactly one key, a frame counter generates a repeat event with the same code every REPEAT_FRAMES stable frames after the initial press. The counter clears on any stable_map change or EN=0.
- Undefined: one event per press; the counter logic is absent.

Test Plan (SCAN_DIV=4, DEBOUNCE_CNT=3, frame = 16 cycles):
- EN=1; hold row2/col1 pressed for 5 frames -> KEY reads 0x19. IRQ=1 if IE=1. A second KEY read returns 0x09 and IRQ=0.
- Press for only 2 frames, then release -> no event, STATUS=0x0.
- Press row0/col0, then add row3/col3 (both within the same debounce window) -> no event, STATUS.HELD=1. After release, a single press of row1/col2 -> KEY=0x16.
- Two presses (0x5, then 0xA) with no read between them -> STATUS=0x3, KEY=0x15. Write STATUS=0x2 -> STATUS=0x1.
- Clear EN during row_idx=2 -> Row=4'hF the next cycle, HELD=0, VALID unchanged. Re-enable -> the scan restarts at row 0.
- Assert HRESETn low mid-dwell -> all outputs immediately at reset values, RAW reads 0x000000F<Col>.
